control_unit: RTL and testbench

Moore-style sequencer for the ProjectB processor datapath. It drives the 8-bit program counter (clear/increment), holds the fetched 16-bit instruction in an internal instruction register, and decodes it into strobes for data memory, register file and ALU. It sits between instruction memory, the PC counter, and the datapath (data RAM, register-file write mux, 16×16 register file, ALU).

---
 rtl/ctrl_pkg.sv | 34 +++
 rtl/ir_reg.sv | 17 +
 rtl/control_unit.sv | 106 ++++++++++
 tb/tb_control_unit.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the ProjectB control unit.
package ctrl_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned STATE_W = 4;
  localparam int unsigned DADDR_W = 8;
  localparam int unsigned RADDR_W = 4;
  localparam int unsigned ALU_W   = 3;

  typedef enum logic [STATE_W-1:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  localparam logic [3:0] OP_NOOP  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_LOAD  = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_HALT  = 4'b0101;

  localparam logic [ALU_W-1:0] ALU_PASS = 3'b000;
  localparam logic [ALU_W-1:0] ALU_ADD  = 3'b001;
  localparam logic [ALU_W-1:0] ALU_SUB  = 3'b010;

endpackage

// File: rtl/ir_reg.sv
// Instruction register: loads on ld, cleared asynchronously by clear_n.
module ir_reg
  import ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               clear_n,
  input  logic               ld,
  input  logic [INSTR_W-1:0] d,
  output logic [INSTR_W-1:0] q
);

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n)  q <= '0;
    else if (ld)   q <= d;
  end

endmodule

// File: rtl/control_unit.sv
// Moore sequencer: fetch/decode/execute FSM driving PC, IR and datapath strobes.
module control_unit
  import ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               clear_n,
  input  logic [INSTR_W-1:0] instr,
  output logic               pc_clr,
  output logic               pc_up,
  output logic               ir_ld,
  output logic [DADDR_W-1:0] d_addr,
  output logic               d_wr,
  output logic               rf_s,
  output logic [RADDR_W-1:0] rf_w_addr,
  output logic               rf_w_en,
  output logic [RADDR_W-1:0] rf_ra_addr,
  output logic [RADDR_W-1:0] rf_rb_addr,
  output logic [ALU_W-1:0]   alu_s0,
  output logic [STATE_W-1:0] state_out,
  output logic [INSTR_W-1:0] ir_out
);

  state_t     state_q, state_d;
  logic [3:0] opcode;

  ir_reg u_ir_reg (
    .clk     (clk),
    .clear_n (clear_n),
    .ld      (ir_ld),
    .d       (instr),
    .q       (ir_out)
  );

  assign opcode    = ir_out[15:12];
  assign state_out = state_q;

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) state_q <= S_INIT;
    else          state_q <= state_d;
  end

  // Next-state: every instruction returns to FETCH; HALT waits for reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_STORE: state_d = S_STORE;
          OP_LOAD:  state_d = S_LOAD_A;
          OP_ADD:   state_d = S_ADD;
          OP_SUB:   state_d = S_SUB;
          OP_HALT:  state_d = S_HALT;
          default:  state_d = S_NOOP;
        endcase
      end
      S_LOAD_A: state_d = S_LOAD_B;
      S_NOOP, S_LOAD_B, S_STORE, S_ADD, S_SUB: state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_INIT;
    endcase
  end

  // Output decode from state and IR; unused address fields stay at zero.
  always_comb begin
    pc_clr     = 1'b0;
    pc_up      = 1'b0;
    ir_ld      = 1'b0;
    d_addr     = '0;
    d_wr       = 1'b0;
    rf_s       = 1'b0;
    rf_w_addr  = '0;
    rf_w_en    = 1'b0;
    rf_ra_addr = '0;
    rf_rb_addr = '0;
    alu_s0     = ALU_PASS;
    case (state_q)
      S_INIT: pc_clr = 1'b1;
      S_FETCH: begin
        ir_ld = 1'b1;
        pc_up = 1'b1;
      end
      S_LOAD_A, S_LOAD_B: begin
        d_addr    = ir_out[11:4];
        rf_w_addr = ir_out[3:0];
        rf_s      = 1'b1;
        rf_w_en   = (state_q == S_LOAD_B);
      end
      S_STORE: begin
        rf_ra_addr = ir_out[11:8];
        d_addr     = ir_out[7:0];
        d_wr       = 1'b1;
      end
      S_ADD, S_SUB: begin
        rf_ra_addr = ir_out[11:8];
        rf_rb_addr = ir_out[7:4];
        rf_w_addr  = ir_out[3:0];
        rf_w_en    = 1'b1;
        alu_s0     = (state_q == S_ADD) ? ALU_ADD : ALU_SUB;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench: program memory + PC counter around control_unit, checked per cycle.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        clear_n;
  logic [15:0] instr;
  logic        pc_clr, pc_up, ir_ld, d_wr, rf_s, rf_w_en;
  logic [7:0]  d_addr;
  logic [3:0]  rf_w_addr, rf_ra_addr, rf_rb_addr, state_out;
  logic [2:0]  alu_s0;
  logic [15:0] ir_out;

  logic [15:0] mem [256];
  logic [7:0]  pc;

  int n_cmp = 0;
  int n_bad = 0;

  control_unit dut (
    .clk        (clk),
    .clear_n    (clear_n),
    .instr      (instr),
    .pc_clr     (pc_clr),
    .pc_up      (pc_up),
    .ir_ld      (ir_ld),
    .d_addr     (d_addr),
    .d_wr       (d_wr),
    .rf_s       (rf_s),
    .rf_w_addr  (rf_w_addr),
    .rf_w_en    (rf_w_en),
    .rf_ra_addr (rf_ra_addr),
    .rf_rb_addr (rf_rb_addr),
    .alu_s0     (alu_s0),
    .state_out  (state_out),
    .ir_out     (ir_out)
  );

  always #5 clk = ~clk;

  // Environment: asynchronous-read program memory and the external PC counter.
  assign instr = mem[pc];
  always @(posedge clk or negedge clear_n) begin
    if (!clear_n)    pc <= 8'd0;
    else if (pc_clr) pc <= 8'd0;
    else if (pc_up)  pc <= pc + 8'd1;
  end

  initial begin
    #200000;
    $error("FAIL timeout: bench exceeded time limit");
    $fatal(1);
  end

  typedef logic [48:0] vec_t;

  function automatic vec_t mk(input logic [3:0] st, input logic clr, input logic up,
                              input logic ld, input logic [7:0] da, input logic dw,
                              input logic rs, input logic [3:0] wa, input logic we,
                              input logic [3:0] ra, input logic [3:0] rb,
                              input logic [2:0] alu, input logic [15:0] ir);
    return {st, clr, up, ld, da, dw, rs, wa, we, ra, rb, alu, ir};
  endfunction

  function automatic vec_t obs();
    return {state_out, pc_clr, pc_up, ir_ld, d_addr, d_wr, rf_s, rf_w_addr, rf_w_en,
            rf_ra_addr, rf_rb_addr, alu_s0, ir_out};
  endfunction

  task automatic check(input string tag, input vec_t exp);
    vec_t o;
    o = obs();
    n_cmp++;
    assert (o === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, exp);
    end
  endtask

  task automatic check_pc(input string tag, input logic [7:0] exp);
    n_cmp++;
    assert (pc === exp) else begin
      n_bad++;
      $error("FAIL %s pc observed=%h expected=%h", tag, pc, exp);
    end
  endtask

  task automatic step(input string tag, input vec_t exp);
    @(negedge clk);
    check(tag, exp);
  endtask

  // Reference: expected cycle-by-cycle outputs of one instruction from its opcode table.
  task automatic run_instr(input logic [15:0] w, input logic [15:0] prev_ir,
                           input logic [7:0] addr);
    logic [3:0] op;
    op = w[15:12];
    @(negedge clk);
    check($sformatf("fetch@%0d", addr), mk(4'd1, 0, 1, 1, 8'h0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0, prev_ir));
    check_pc($sformatf("pc@%0d", addr), addr);
    step($sformatf("decode@%0d", addr), mk(4'd2, 0, 0, 0, 8'h0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0, w));
    case (op)
      4'd1: step("store", mk(4'd6, 0, 0, 0, w[7:0], 1, 0, 4'h0, 0, w[11:8], 4'h0, 3'd0, w));
      4'd2: begin
        step("load_a", mk(4'd4, 0, 0, 0, w[11:4], 0, 1, w[3:0], 0, 4'h0, 4'h0, 3'd0, w));
        step("load_b", mk(4'd5, 0, 0, 0, w[11:4], 0, 1, w[3:0], 1, 4'h0, 4'h0, 3'd0, w));
      end
      4'd3: step("add", mk(4'd7, 0, 0, 0, 8'h0, 0, 0, w[3:0], 1, w[11:8], w[7:4], 3'b001, w));
      4'd4: step("sub", mk(4'd8, 0, 0, 0, 8'h0, 0, 0, w[3:0], 1, w[11:8], w[7:4], 3'b010, w));
      4'd5: step("halt", mk(4'd9, 0, 0, 0, 8'h0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0, w));
      default: step("noop", mk(4'd3, 0, 0, 0, 8'h0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0, w));
    endcase
  endtask

  vec_t rst_vec;
  logic [15:0] prog [$];
  logic [15:0] prev;
  logic [15:0] hw;
  logic [3:0]  rop;

  initial begin
    rst_vec = mk(4'd0, 1, 0, 0, 8'h0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0, 16'h0000);
    prog = '{16'h21B5, 16'h1A42, 16'h3123, 16'h4567, 16'hF000};
    for (int i = 0; i < 30; i++) begin
      do rop = 4'($urandom_range(0, 15)); while (rop == 4'd5);
      prog.push_back({rop, 12'($urandom)});
    end
    prog.push_back(16'h5000);
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    foreach (prog[i]) mem[i] = prog[i];

    // Reset held for two cycles
    clear_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset", rst_vec);
    clear_n = 1'b1;
    #1 check("init", rst_vec);

    prev = 16'h0000;
    foreach (prog[i]) begin
      run_instr(prog[i], prev, 8'(i));
      prev = prog[i];
    end

    // HALT persists with instr changing underneath
    for (int c = 0; c < 20; c++) begin
      mem[pc] = 16'($urandom);
      step($sformatf("halt_hold%0d", c), mk(4'd9, 0, 0, 0, 8'h0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0, 16'h5000));
    end

    clear_n = 1'b0;
    #1 check("halt_reset", rst_vec);
    @(negedge clk);
    clear_n = 1'b1;
    #1 check("reinit", rst_vec);

    // Abort a LOAD during LOAD_B
    @(negedge clk);
    check("re_fetch", mk(4'd1, 0, 1, 1, 8'h0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0, 16'h0000));
    hw = 16'h21B5;
    step("re_decode", mk(4'd2, 0, 0, 0, 8'h0, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'd0, hw));
    step("re_load_a", mk(4'd4, 0, 0, 0, 8'h1B, 0, 1, 4'h5, 0, 4'h0, 4'h0, 3'd0, hw));
    step("re_load_b", mk(4'd5, 0, 0, 0, 8'h1B, 0, 1, 4'h5, 1, 4'h0, 4'h0, 3'd0, hw));
    #1 clear_n = 1'b0;
    #1 check("abort_load_b", rst_vec);
    @(posedge clk);
    #1 check("abort_hold", rst_vec);
    clear_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
